// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared memory-interface widths, responder states and address helper
package mem_responder_pkg;
  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;
  typedef enum logic [2:0] {IDLE, ACC, ACC2, HOLD, DRAIN} state_t;
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(1);
  endfunction
endpackage

// File: rtl/mem_responder.sv
// mem_responder: answers core read/write/fetch requests with cack/busy/ready and performs them as 16-bit backend req/ack words
module mem_responder
  import mem_responder_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  input  logic                cpu_read,
  input  logic                cpu_write,
  input  logic                cpu_instr,
  input  logic                cpu_read_done,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic [2*DATA_W-1:0] cpu_instr_data,
  output logic                mem_cack,
  output logic                mem_busy,
  output logic                mem_ready,
  output logic                b_req,
  output logic                b_we,
  output logic [ADDR_W-1:0]   b_addr,
  output logic [DATA_W-1:0]   b_wdata,
  input  logic [DATA_W-1:0]   b_rdata,
  input  logic                b_ack
);
  state_t state;
  logic instr;
  logic [DATA_W-1:0] lo;
  logic no_req;
  always_comb no_req = !cpu_read && !cpu_write;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      instr <= 1'b0;
      lo <= '0;
      cpu_rdata <= '0;
      cpu_instr_data <= '0;
      mem_cack <= 1'b0;
      mem_busy <= 1'b0;
      mem_ready <= 1'b0;
      b_req <= 1'b0;
      b_we <= 1'b0;
      b_addr <= '0;
      b_wdata <= '0;
    end else begin
      mem_cack <= 1'b0;
      case (state)
        IDLE:
          if (!no_req) begin
            state <= ACC;
            mem_cack <= 1'b1;
            mem_busy <= 1'b1;
            b_req <= 1'b1;
            b_we <= cpu_write;
            b_addr <= cpu_addr;
            instr <= !cpu_write && cpu_instr;
            if (cpu_write) b_wdata <= cpu_wdata;
          end
        ACC, ACC2:
          // a dropped request lets the in-flight word finish without publishing a result
          if (no_req) begin
            state <= b_ack ? IDLE : DRAIN;
            b_req <= !b_ack;
            mem_busy <= !b_ack;
          end else if (b_ack) begin
            if (state == ACC && instr) begin
              state <= ACC2;
              lo <= b_rdata;
              b_addr <= next_addr(b_addr);
            end else begin
              state <= HOLD;
              b_req <= 1'b0;
              mem_busy <= 1'b0;
              mem_ready <= 1'b1;
              if (state == ACC2) cpu_instr_data <= {b_rdata, lo};
              else if (!b_we) cpu_rdata <= b_rdata;
            end
          end
        HOLD:
          if (cpu_read_done || no_req) begin
            state <= IDLE;
            mem_ready <= 1'b0;
          end
        DRAIN:
          if (b_ack) begin
            state <= IDLE;
            b_req <= 1'b0;
            mem_busy <= 1'b0;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: vector table, corner sequences and randomized transactions against a transaction-level memory model
module tb_mem_responder;
  logic clk = 0, rst = 0;
  logic [19:0] cpu_addr = 0;
  logic [15:0] cpu_wdata = 0;
  logic cpu_read = 0, cpu_write = 0, cpu_instr = 0, cpu_read_done = 0;
  logic [15:0] cpu_rdata;
  logic [31:0] cpu_instr_data;
  logic mem_cack, mem_busy, mem_ready, b_req, b_we;
  logic [19:0] b_addr;
  logic [15:0] b_wdata, b_rdata;
  logic b_ack;

  mem_responder dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_instr(cpu_instr),
    .cpu_read_done(cpu_read_done), .cpu_rdata(cpu_rdata), .cpu_instr_data(cpu_instr_data),
    .mem_cack(mem_cack), .mem_busy(mem_busy), .mem_ready(mem_ready),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(b_rdata), .b_ack(b_ack)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int waits = 0, acks = 0, wcnt = 0;
  logic [19:0] ack_log [int];
  logic [15:0] dev_mem [logic [19:0]];
  logic [15:0] ref_mem [logic [19:0]];
  logic [15:0] exp_rdata_last = 0;
  logic [31:0] exp_instr_last = 0;

  function automatic logic [15:0] pat(input logic [19:0] a);
    return a[15:0] ^ 16'hC3A5;
  endfunction
  function automatic logic [15:0] dev_rd(input logic [19:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : pat(a);
  endfunction
  function automatic logic [15:0] ref_rd(input logic [19:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : pat(a);
  endfunction
  function automatic logic [19:0] wrap1(input logic [19:0] a);
    return 20'((32'(a) + 1) % 32'h100000);
  endfunction

  // backend device: acks after `waits` idle cycles of a held request
  initial begin
    b_ack = 0;
    b_rdata = 0;
    forever begin
      @(posedge clk);
      #1;
      if (b_req) begin
        if (wcnt == waits) begin
          b_ack = 1;
          b_rdata = dev_rd(b_addr);
          if (b_we) dev_mem[b_addr] = b_wdata;
          ack_log[acks] = b_addr;
          acks++;
          wcnt = 0;
        end else begin
          b_ack = 0;
          wcnt++;
        end
      end else begin
        b_ack = 0;
        wcnt = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic preload(input logic [19:0] a, input logic [15:0] d);
    dev_mem[a] = d;
    ref_mem[a] = d;
  endtask

  task automatic xfer(input logic rd, input logic wr, input logic ins, input logic [19:0] addr,
                      input logic [15:0] wd, input int w, input int exp_ready, input logic [31:0] exp_data);
    int cack_at, ready_at, ncack, start, words;
    logic overlap;
    words = (!wr && ins) ? 2 : 1;
    start = acks;
    waits = w;
    cpu_addr = addr; cpu_wdata = wd; cpu_read = rd; cpu_write = wr; cpu_instr = ins;
    cack_at = -1; ready_at = -1; ncack = 0; overlap = 0;
    for (int c = 1; c <= 40 && ready_at < 0; c++) begin
      tick();
      if (mem_cack) begin
        ncack++;
        if (cack_at < 0) begin
          cack_at = c;
          chk("cack_breq", 32'(b_req), 1);
          chk("cack_bwe", 32'(b_we), 32'(wr));
          chk("cack_baddr", 32'(b_addr), 32'(addr));
          if (wr) chk("cack_bwdata", 32'(b_wdata), 32'(wd));
        end
      end
      if (mem_busy && mem_ready) overlap = 1;
      if (mem_ready) ready_at = c;
    end
    if (wr) ref_mem[addr] = wd;
    else if (ins) exp_instr_last = exp_data;
    else exp_rdata_last = exp_data[15:0];
    chk("cack_cycle", 32'(cack_at), 1);
    chk("cack_count", 32'(ncack), 1);
    chk("ready_cycle", 32'(ready_at), 32'(exp_ready));
    chk("busy_ready_overlap", 32'(overlap), 0);
    chk("hold_breq", 32'(b_req), 0);
    chk("word_count", 32'(acks - start), 32'(words));
    if (words == 2) chk("second_baddr", 32'(ack_log[start + 1]), 32'(wrap1(addr)));
    chk("rdata", 32'(cpu_rdata), 32'(exp_rdata_last));
    chk("instr_data", cpu_instr_data, exp_instr_last);
    tick();
    chk("hold_ready", 32'(mem_ready), 1);
    chk("hold_rdata", 32'(cpu_rdata), 32'(exp_rdata_last));
    cpu_read = 0; cpu_write = 0; cpu_instr = 0; cpu_read_done = 1;
    tick();
    chk("exit_ready", 32'(mem_ready), 0);
    cpu_read_done = 0;
    tick();
  endtask

  typedef struct {
    logic rd, wr, ins;
    logic [19:0] addr;
    logic [15:0] wd;
    int w, exp_ready;
    logic [31:0] exp_data;
  } vec_t;

  initial begin
    vec_t vt [7];
    int saw, start;
    logic [19:0] a;
    logic [15:0] wd;
    int op, w, words;
    vt[0] = '{1, 0, 0, 20'h00123, 16'h0000, 0, 2, 32'h0000BEEF};
    vt[1] = '{0, 1, 0, 20'h0FFFF, 16'h5A5A, 3, 5, 32'h0};
    vt[2] = '{1, 0, 0, 20'h0FFFF, 16'h0000, 0, 2, 32'h00005A5A};
    vt[3] = '{1, 0, 1, 20'hFFFFF, 16'h0000, 0, 3, 32'h22221111};
    vt[4] = '{1, 1, 0, 20'h00010, 16'h1234, 1, 3, 32'h0};
    vt[5] = '{1, 0, 0, 20'h00010, 16'h0000, 2, 4, 32'h00001234};
    vt[6] = '{1, 0, 1, 20'h00010, 16'h0000, 1, 5, 32'hABCD1234};
    preload(20'h00123, 16'hBEEF);
    preload(20'hFFFFF, 16'h1111);
    preload(20'h00000, 16'h2222);
    preload(20'h00011, 16'hABCD);

    repeat (3) tick();
    chk("rst_ctrl", 32'({mem_cack, mem_busy, mem_ready, b_req, b_we}), 0);
    chk("rst_baddr", 32'(b_addr), 0);
    chk("rst_rdata", 32'(cpu_rdata), 0);
    chk("rst_instr", cpu_instr_data, 0);
    rst = 1;
    tick();

    for (int i = 0; i < 7; i++)
      xfer(vt[i].rd, vt[i].wr, vt[i].ins, vt[i].addr, vt[i].wd, vt[i].w, vt[i].exp_ready, vt[i].exp_data);

    // abort: request dropped in ACC, backend acks two cycles later
    start = acks;
    waits = 3; cpu_addr = 20'h00123; cpu_read = 1;
    tick();
    chk("abort_cack", 32'(mem_cack), 1);
    tick();
    cpu_read = 0;
    saw = 0;
    for (int c = 3; c <= 9; c++) begin
      tick();
      if (mem_ready) saw = 1;
    end
    chk("abort_no_ready", 32'(saw), 0);
    chk("abort_rdata", 32'(cpu_rdata), 32'(exp_rdata_last));
    chk("abort_idle", 32'({mem_busy, b_req}), 0);
    chk("abort_word_done", 32'(acks - start), 1);

    // read_done with the request still high: ready drops next cycle, new cack one cycle later
    waits = 0; cpu_addr = 20'h00010; cpu_read = 1;
    tick(); tick();
    chk("rd_done_ready", 32'(mem_ready), 1);
    chk("rd_done_rdata", 32'(cpu_rdata), 16'h1234);
    cpu_read_done = 1; cpu_addr = 20'h00123;
    tick();
    cpu_read_done = 0;
    chk("rd_done_drop", 32'({mem_ready, mem_cack}), 0);
    tick();
    chk("rd_done_next_cack", 32'(mem_cack), 1);
    tick();
    exp_rdata_last = 16'hBEEF;
    chk("rd_done_next_data", 32'({mem_ready, cpu_rdata}), 32'h1BEEF);
    cpu_read = 0;
    tick(); tick();

    // reset during ACC2
    waits = 2; cpu_addr = 20'h00010; cpu_read = 1; cpu_instr = 1;
    repeat (4) tick();
    chk("acc2_baddr", 32'(b_addr), 20'h00011);
    rst = 0;
    tick();
    chk("midrst_ctrl", 32'({mem_cack, mem_busy, mem_ready, b_req, b_we}), 0);
    chk("midrst_baddr", 32'(b_addr), 0);
    chk("midrst_bwdata", 32'(b_wdata), 0);
    chk("midrst_data", {cpu_rdata, cpu_instr_data[15:0]}, 0);
    exp_rdata_last = 0; exp_instr_last = 0;
    rst = 1; cpu_read = 0; cpu_instr = 0;
    tick();
    xfer(1, 0, 0, 20'h00123, 16'h0, 0, 2, 32'h0000BEEF);

    for (int i = 0; i < 24; i++) begin
      op = $urandom_range(0, 3);
      case ($urandom_range(0, 3))
        0: a = 20'hFFFFF;
        1: a = 20'h00000;
        2: a = 20'h00010 + 20'($urandom_range(0, 3));
        default: a = 20'($urandom);
      endcase
      wd = 16'($urandom);
      w = $urandom_range(0, 2);
      words = (op == 2) ? 2 : 1;
      xfer(op != 1, op == 1 || op == 3, op == 2, a, wd, w, 1 + words * (w + 1),
           {ref_rd(wrap1(a)), ref_rd(a)} & ((op == 2) ? 32'hFFFFFFFF : 32'h0000FFFF));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the core's data/instruction memory request interface. It accepts the core's read, write and 32-bit instruction-fetch requests, answers with the cack/busy/ready handshake, and performs the accesses as 16-bit word transactions on a simple req/ack backend port (SDRAM controller or on-chip RAM). It sits between the core's external memory pins and the memory subsystem.

## Interface
- ADDR_W, 20, word address width on both sides
- DATA_W, 16, data word width; the instruction path is 2*DATA_W
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-low
- cpu_addr  in  ADDR_W  request word address
- cpu_wdata  in  DATA_W  write data
- cpu_read  in  1  read request (level, held until completion)
- cpu_write  in  1  write request (level, held until completion)
- cpu_instr  in  1  qualifies cpu_read as a 32-bit instruction fetch
- cpu_read_done  in  1  core has consumed read data
- cpu_rdata  out  DATA_W  data read result
- cpu_instr_data  out  2*DATA_W  instruction fetch result
- mem_cack  out  1  one-cycle command-accepted pulse
- mem_busy  out  1  access in progress
- mem_ready  out  1  result valid / write complete
- b_req  out  1  backend request, held until b_ack
- b_we  out  1  backend write enable
- b_addr  out  ADDR_W  backend word address
- b_wdata  out  DATA_W  backend write data
- b_rdata  in  DATA_W  backend read data, valid with b_ack
- b_ack  in  1  one-cycle backend completion; ignored while b_req is low

## Operation
- All outputs are registered. Reset (rst low at a clk edge) sets every output to 0 and the state to IDLE. Reset mid-access drops b_req immediately; the backend must tolerate an abandoned request.
- States: IDLE, ACC, ACC2, HOLD, DRAIN.
- IDLE: sample the request. If cpu_write is high, latch the address and data, then go to ACC with b_we=1. Write wins if cpu_read and cpu_write are both high. If only cpu_read is high, latch the address and cpu_instr, then go to ACC with b_we=0. On entry to ACC: mem_cack=1 for one cycle, mem_busy=1, b_req=1, b_addr=latched address.
- ACC, on b_ack:
  - write → HOLD
  - data read → capture b_rdata into cpu_rdata, then HOLD
  - instruction fetch → capture b_rdata into cpu_instr_data[15:0], then ACC2 with b_addr=addr+1
- Address increment wraps modulo 2^ADDR_W (0xFFFFF+1 = 0x00000). b_req stays high across the ACC→ACC2 transition.
- ACC2, on b_ack: capture b_rdata into cpu_instr_data[31:16], then HOLD.
- HOLD: b_req=0, mem_busy=0, mem_ready=1, and the result is held stable. Leave to IDLE when cpu_read_done=1 or when both cpu_read and cpu_write are low. In the exit cycle mem_ready=0. A request still present in IDLE afterwards starts a new access.
- Abort: if both cpu_read and cpu_write drop during ACC or ACC2, set an abort flag. The in-flight backend word completes (DRAIN behaviour); then go to IDLE with no mem_ready and no result update.
- cpu_rdata and cpu_instr_data keep their last values outside HOLD.

## Timing
- Request seen at cycle 0 → mem_cack, mem_busy and b_req high at cycle 1.
- Zero-wait backend (b_ack in the same cycle b_req is first high):
  - data read/write: mem_ready at cycle 2
  - instruction fetch: second b_addr at cycle 2, mem_ready at cycle 3
- Each backend wait cycle adds one cycle of latency.
- mem_busy and mem_ready are never high together. mem_cack occurs exactly once per accepted request.
- cpu_read_done sampled at cycle n → mem_ready low at n+1; the earliest next mem_cack is at n+2.

## Structure
- State encoding localparams and ADDR_W/DATA_W defaults go in the shared memory-interface package/header, alongside the core's bus constants.
- A single flat module: FSM, request latch and result registers. No sub-module is needed. The backend-side request/ack holder may be factored into mem_resp_port if it is reused by the fetch path.

## Test plan
- Read addr 0x00123 with backend returning 0xBEEF after 0 waits → cack@1, ready@2, cpu_rdata=0xBEEF, held until read_done.
- Write 0x5A5A to 0x0FFFF with a 3-wait ack → b_we=1, b_addr=0x0FFFF, b_wdata=0x5A5A; ready@5; no second b_req.
- Instruction fetch at 0xFFFFF returning 0x1111 then 0x2222 → second b_addr=0x00000; cpu_instr_data=0x22221111.
- cpu_read and cpu_write both high at 0x00010 → only a write is performed; b_we=1.
- Drop cpu_read during ACC, backend acks 2 cycles later → no mem_ready, cpu_rdata unchanged, back to IDLE.
- rst low during ACC2 → next cycle all outputs 0; a following read completes normally.
